// File: rtl/pixel_stats_if.sv
// Pixel stream bundle feeding the per-frame statistics engine.
// Carries one pixel per valid cycle plus an end-of-frame marker.
interface pixel_stats_if #(
  parameter int PIXEL_WIDTH = 8
);
  // No backpressure: a pixel transfers on every rising edge where pixel_valid is high.
  // in_last only has meaning on a cycle where pixel_valid is also high.
  logic                   pixel_valid;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic                   in_last;

  modport master (output pixel_valid, output pixel_data, output in_last);
  modport slave  (input  pixel_valid, input  pixel_data, input  in_last);
endinterface

// File: rtl/pixel_stats.sv
// Per-frame pixel statistics: count, sum, min, max and above-threshold count,
// latched at frame end with a one-cycle done pulse; saturating accumulators.
module pixel_stats #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int COUNT_WIDTH  = 32,
  parameter int SUM_WIDTH    = 40,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  pixel_stats_if.slave           pix,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] total_pixels,
  output logic [SUM_WIDTH-1:0]   pixel_sum,
  output logic [PIXEL_WIDTH-1:0] pixel_min,
  output logic [PIXEL_WIDTH-1:0] pixel_max,
  output logic [COUNT_WIDTH-1:0] above_count,
  output logic                   overflow,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, above_q, above_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [PIXEL_WIDTH-1:0] min_q, min_d, max_q, max_d, thr_q, thr_d;
  logic                   ovf_q, ovf_d;

  logic [COUNT_WIDTH-1:0] tot_q, tot_d, oabove_q, oabove_d;
  logic [SUM_WIDTH-1:0]   osum_q, osum_d;
  logic [PIXEL_WIDTH-1:0] omin_q, omin_d, omax_q, omax_d;
  logic                   oovf_q, oovf_d;
  logic                   done_q, done_d, busy_q;

  // Accumulator values as they would be after absorbing the current pixel.
  logic                   cnt_full, above_full, above_hit, sum_carry;
  logic [SUM_WIDTH:0]     sum_ext;
  logic [COUNT_WIDTH-1:0] cnt_add, above_add;
  logic [SUM_WIDTH-1:0]   sum_add;
  logic [PIXEL_WIDTH-1:0] min_add, max_add;
  logic                   ovf_add;

  assign cnt_full   = &cnt_q;
  assign above_full = &above_q;
  assign above_hit  = pix.pixel_data > thr_q;
  assign sum_ext    = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - PIXEL_WIDTH){1'b0}}, pix.pixel_data};
  assign sum_carry  = sum_ext[SUM_WIDTH];
  assign cnt_add    = cnt_full ? cnt_q : cnt_q + COUNT_WIDTH'(1);
  assign above_add  = (above_hit && !above_full) ? above_q + COUNT_WIDTH'(1) : above_q;
  assign sum_add    = sum_carry ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
  assign min_add    = (pix.pixel_data < min_q) ? pix.pixel_data : min_q;
  assign max_add    = (pix.pixel_data > max_q) ? pix.pixel_data : max_q;
  assign ovf_add    = ovf_q | cnt_full | (above_hit & above_full) | sum_carry;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    min_d    = min_q;
    max_d    = max_q;
    above_d  = above_q;
    ovf_d    = ovf_q;
    thr_d    = thr_q;
    tot_d    = tot_q;
    osum_d   = osum_q;
    omin_d   = omin_q;
    omax_d   = omax_q;
    oabove_d = oabove_q;
    oovf_d   = oovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNT;
          cnt_d   = '0;
          sum_d   = '0;
          min_d   = '1;
          max_d   = '0;
          above_d = '0;
          ovf_d   = 1'b0;
          thr_d   = threshold;
        end
      end
      S_COUNT: begin
        if (abort) begin
          // Abort wins over a coincident pixel; published results stay untouched.
          state_d = S_IDLE;
          cnt_d   = '0;
          sum_d   = '0;
          min_d   = '1;
          max_d   = '0;
          above_d = '0;
          ovf_d   = 1'b0;
        end else if (pix.pixel_valid) begin
          cnt_d   = cnt_add;
          sum_d   = sum_add;
          min_d   = min_add;
          max_d   = max_add;
          above_d = above_add;
          ovf_d   = ovf_add;
          if (pix.in_last) begin
            tot_d    = cnt_add;
            osum_d   = sum_add;
            omin_d   = min_add;
            omax_d   = max_add;
            oabove_d = above_add;
            oovf_d   = ovf_add;
            done_d   = 1'b1;
            if (AUTO_RESTART) begin
              cnt_d   = '0;
              sum_d   = '0;
              min_d   = '1;
              max_d   = '0;
              above_d = '0;
              ovf_d   = 1'b0;
              thr_d   = threshold;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
      above_q  <= '0;
      ovf_q    <= 1'b0;
      thr_q    <= '0;
      tot_q    <= '0;
      osum_q   <= '0;
      omin_q   <= '1;
      omax_q   <= '0;
      oabove_q <= '0;
      oovf_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
      above_q  <= above_d;
      ovf_q    <= ovf_d;
      thr_q    <= thr_d;
      tot_q    <= tot_d;
      osum_q   <= osum_d;
      omin_q   <= omin_d;
      omax_q   <= omax_d;
      oabove_q <= oabove_d;
      oovf_q   <= oovf_d;
      done_q   <= done_d;
      busy_q   <= (state_d == S_COUNT);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign total_pixels = tot_q;
  assign pixel_sum    = osum_q;
  assign pixel_min    = omin_q;
  assign pixel_max    = omax_q;
  assign above_count  = oabove_q;
  assign overflow     = oovf_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pixel_stats.sv
// Bench for pixel_stats: three instances (default, auto-restart, 4-bit counters)
// share one stimulus stream and are checked against a frame-level reference model.
module tb_pixel_stats;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] threshold;
  pixel_stats_if pif ();

  logic [63:0] o_tot[N], o_sum[N], o_min[N], o_max[N], o_above[N];
  logic [63:0] o_ovf[N], o_done[N], o_busy[N], o_st[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 32;
    localparam bit AR = (g == 1);
    logic          busy, done, ovf;
    logic [CW-1:0] tot, above;
    logic [39:0]   sum;
    logic [7:0]    mn, mx;
    logic [1:0]    st;
    pixel_stats #(.PIXEL_WIDTH(8), .COUNT_WIDTH(CW), .SUM_WIDTH(40), .AUTO_RESTART(AR)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pix(pif),
      .threshold(threshold), .busy(busy), .done(done), .total_pixels(tot),
      .pixel_sum(sum), .pixel_min(mn), .pixel_max(mx), .above_count(above),
      .overflow(ovf), .state_o(st)
    );
    assign o_tot[g]   = 64'(tot);
    assign o_sum[g]   = 64'(sum);
    assign o_min[g]   = 64'(mn);
    assign o_max[g]   = 64'(mx);
    assign o_above[g] = 64'(above);
    assign o_ovf[g]   = 64'(ovf);
    assign o_done[g]  = 64'(done);
    assign o_busy[g]  = 64'(busy);
    assign o_st[g]    = 64'(st);
  end

  // ---------------- reference model (frame level) ----------------
  typedef enum {M_IDLE, M_COUNT, M_DONE} mstate_e;
  int              cw_p[N] = '{32, 32, 4};
  bit              ar_p[N] = '{1'b0, 1'b1, 1'b0};
  mstate_e         m_st[N];
  longint unsigned m_n[N], m_sum[N], m_above[N];
  int              m_min[N], m_max[N], m_thr[N];
  logic [63:0]     e_tot[N], e_sum[N], e_min[N], e_max[N], e_above[N];
  logic [63:0]     e_ovf[N], e_done[N], e_busy[N];

  int checks = 0;
  int errors = 0;
  int done_cnt_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void frame_clear(int i, int thr);
    m_n[i] = 0; m_sum[i] = 0; m_above[i] = 0;
    m_min[i] = 256; m_max[i] = -1; m_thr[i] = thr;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = M_IDLE;
      frame_clear(i, 0);
      e_tot[i] = 0; e_sum[i] = 0; e_min[i] = 64'd255; e_max[i] = 0;
      e_above[i] = 0; e_ovf[i] = 0; e_done[i] = 0; e_busy[i] = 0;
    end
  endfunction

  function automatic void publish(int i);
    longint unsigned maxc, maxs;
    maxc = (64'd1 << cw_p[i]) - 64'd1;
    maxs = (64'd1 << 40) - 64'd1;
    e_tot[i]   = (m_n[i] > maxc) ? maxc : m_n[i];
    e_sum[i]   = (m_sum[i] > maxs) ? maxs : m_sum[i];
    e_above[i] = (m_above[i] > maxc) ? maxc : m_above[i];
    e_min[i]   = 64'(m_min[i]);
    e_max[i]   = 64'(m_max[i]);
    e_ovf[i]   = 64'((m_n[i] > maxc) || (m_sum[i] > maxs) || (m_above[i] > maxc));
  endfunction

  // Applies one clock edge worth of behaviour using the inputs currently driven.
  function automatic void model_edge();
    int d;
    d = int'(pif.pixel_data);
    for (int i = 0; i < N; i++) begin
      e_done[i] = 0;
      case (m_st[i])
        M_IDLE: if (start) begin
          m_st[i] = M_COUNT;
          frame_clear(i, int'(threshold));
        end
        M_COUNT: if (abort) begin
          m_st[i] = M_IDLE;
          frame_clear(i, 0);
        end else if (pif.pixel_valid) begin
          m_n[i]++;
          m_sum[i] += longint'(d);
          if (d > m_thr[i]) m_above[i]++;
          if (d < m_min[i]) m_min[i] = d;
          if (d > m_max[i]) m_max[i] = d;
          if (pif.in_last) begin
            publish(i);
            e_done[i] = 1;
            if (ar_p[i]) frame_clear(i, int'(threshold));
            else m_st[i] = M_DONE;
          end
        end
        M_DONE: if (!start) m_st[i] = M_IDLE;
        default: m_st[i] = M_IDLE;
      endcase
      e_busy[i] = 64'(m_st[i] == M_COUNT);
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.done", i),  o_done[i],  e_done[i]);
      chk($sformatf("u%0d.busy", i),  o_busy[i],  e_busy[i]);
      chk($sformatf("u%0d.total", i), o_tot[i],   e_tot[i]);
      chk($sformatf("u%0d.sum", i),   o_sum[i],   e_sum[i]);
      chk($sformatf("u%0d.min", i),   o_min[i],   e_min[i]);
      chk($sformatf("u%0d.max", i),   o_max[i],   e_max[i]);
      chk($sformatf("u%0d.above", i), o_above[i], e_above[i]);
      chk($sformatf("u%0d.ovf", i),   o_ovf[i],   e_ovf[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int d, input bit l);
    pif.pixel_valid = v;
    pif.pixel_data  = 8'(d);
    pif.in_last     = l;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    if (o_done[1] == 64'd1) done_cnt_r++;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int len;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; threshold = 8'd0;
    drive(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    for (int i = 0; i < N; i++) chk($sformatf("reset.state%0d", i), o_st[i], 64'd0);
    rst_n = 1'b1;

    // Basic frame, start held high through S_DONE with stray pixels
    threshold = 8'd128; start = 1'b1;
    step();
    drive(1, 10, 0);  step();
    drive(1, 200, 0); step();
    drive(1, 128, 0); step();
    drive(1, 129, 1); step();
    chk("t1.done", o_done[0], 64'd1);
    chk("t1.total", o_tot[0], 64'd4);
    chk("t1.sum", o_sum[0], 64'd467);
    chk("t1.min", o_min[0], 64'd10);
    chk("t1.max", o_max[0], 64'd200);
    chk("t1.above", o_above[0], 64'd2);
    chk("t1.ovf", o_ovf[0], 64'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 77, k[0]); step();
    end
    chk("t1.done_once", o_done[0], 64'd0);
    chk("t1.no_retrigger", o_busy[0], 64'd0);
    chk("t1.hold_total", o_tot[0], 64'd4);
    start = 1'b0; drive(0, 0, 0); step();

    // Back-to-back frames (auto-restart instance)
    abort = 1'b1; step(); abort = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    done_cnt_r = 0;
    drive(1, 5, 0);   step();
    drive(1, 6, 1);   step();
    drive(1, 250, 1); step();
    drive(0, 0, 0);   step();
    chk("ar.pulses", 64'(done_cnt_r), 64'd2);
    chk("ar.total", o_tot[1], 64'd1);
    chk("ar.sum", o_sum[1], 64'd250);
    chk("ar.min", o_min[1], 64'd250);
    chk("ar.max", o_max[1], 64'd250);
    chk("ar.busy", o_busy[1], 64'd1);

    // Abort with the last pixel
    start = 1'b1; step(); start = 1'b0;
    drive(1, 1, 0); step();
    drive(1, 2, 0); step();
    drive(1, 3, 1); abort = 1'b1; step();
    abort = 1'b0; drive(0, 0, 0);
    chk("abort.done", o_done[0], 64'd0);
    chk("abort.busy", o_busy[0], 64'd0);
    chk("abort.total", o_tot[0], 64'd2);
    chk("abort.sum", o_sum[0], 64'd11);
    chk("abort.min", o_min[0], 64'd5);
    chk("abort.max", o_max[0], 64'd6);
    step();

    // Saturation with 4-bit counters
    threshold = 8'd0; start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, k == 19); step();
    end
    chk("sat.total", o_tot[2], 64'd15);
    chk("sat.above", o_above[2], 64'd15);
    chk("sat.ovf", o_ovf[2], 64'd1);
    chk("sat.sum", o_sum[2], 64'd20);
    chk("sat.wide_total", o_tot[0], 64'd20);
    chk("sat.wide_ovf", o_ovf[0], 64'd0);
    drive(0, 0, 0); step();

    // Pixels while idle are ignored
    for (int k = 0; k < 3; k++) begin
      drive(1, $urandom_range(0, 255), $urandom_range(0, 1)); step();
    end

    // Random frames with gaps and junk outside frames
    for (int f = 0; f < 8; f++) begin
      threshold = 8'($urandom_range(0, 255));
      start = 1'b1; drive(0, 0, 0); step(); start = 1'b0;
      len = $urandom_range(1, 12);
      for (int p = 0; p < len; p++) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          drive(0, $urandom_range(0, 255), $urandom_range(0, 1)); step();
        end
        drive(1, $urandom_range(0, 255), p == len - 1); step();
      end
      drive(1, $urandom_range(0, 255), 0); step();
      drive(0, 0, 0); step(); step();
    end

    // Asynchronous reset mid-frame
    start = 1'b1; step(); start = 1'b0;
    drive(1, 50, 0); step();
    drive(1, 60, 0); step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst.min", o_min[0], 64'd255);
    chk("arst.state", o_st[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0);
    threshold = 8'd100; start = 1'b1; step(); start = 1'b0;
    drive(1, 100, 0); step();
    drive(1, 101, 1); step();
    chk("post.total", o_tot[0], 64'd2);
    chk("post.sum", o_sum[0], 64'd201);
    chk("post.min", o_min[0], 64'd100);
    chk("post.max", o_max[0], 64'd101);
    chk("post.above", o_above[0], 64'd1);
    drive(0, 0, 0); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_stats.md
Name: pixel_stats

Overview:
Per-frame pixel statistics engine for the thresholding pipeline. It replaces the plain pixel counter and accumulates, per frame:
- pixel count
- intensity sum
- minimum and maximum intensity
- count of pixels above a programmable threshold

Results are latched into output registers at frame end, with a one-cycle done pulse. It supports back-to-back frames (auto-restart), frame abort and saturating arithmetic. It sits on the pixel stream ahead of the threshold-selection logic.

Parameters:
PIXEL_WIDTH, 8, bits per pixel intensity
COUNT_WIDTH, 32, width of pixel and above-threshold counters
SUM_WIDTH, 40, width of intensity accumulator
AUTO_RESTART, 0, 1 = after frame end begin next frame immediately; 0 = stop in S_DONE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level request to begin a frame
abort  in  1  discard current frame
pixel_valid  in  1  pixel_data valid this cycle
pixel_data  in  PIXEL_WIDTH  pixel intensity
in_last  in  1  qualifies last pixel of frame (with pixel_valid)
threshold  in  PIXEL_WIDTH  comparison level, sampled at frame start
busy  out  1  high in S_COUNT
done  out  1  one-cycle pulse, results updated
total_pixels  out  COUNT_WIDTH  latched pixel count
pixel_sum  out  SUM_WIDTH  latched intensity sum
pixel_min  out  PIXEL_WIDTH  latched minimum
pixel_max  out  PIXEL_WIDTH  latched maximum
above_count  out  COUNT_WIDTH  latched count of pixel_data > threshold
overflow  out  1  latched: a counter or the sum saturated in that frame

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State S_IDLE.
  - All outputs 0, except pixel_min, which resets to all ones.
  - Accumulators cleared: count/sum/above 0, min all ones, max 0, overflow 0.
- States: S_IDLE, S_COUNT, S_DONE (2-bit encoding).
- S_IDLE:
  - start=1 -> S_COUNT.
  - On that edge: clear accumulators and register threshold.
- S_COUNT, pixel_valid=1 and abort=0:
  - count += 1; sum += pixel_data.
  - Update min and max.
  - above += 1 if pixel_data > threshold_reg (strict).
- S_COUNT, pixel_valid=1 and in_last=1 and abort=0 (frame end):
  - Output registers load the accumulator values including this pixel; done=1 next cycle for exactly one cycle.
  - AUTO_RESTART=0: -> S_DONE.
  - AUTO_RESTART=1: stay in S_COUNT; clear accumulators; re-sample threshold on the same edge. A pixel on the very next cycle belongs to the new frame.
- S_COUNT, abort=1:
  - -> S_IDLE; accumulators cleared.
  - Output registers unchanged; no done pulse.
  - abort has priority over a simultaneous valid/last pixel, which is dropped.
- S_DONE: wait for start=0 -> S_IDLE. start held high does not retrigger; abort ignored.
- start asserted while in S_COUNT: ignored. pixel_valid outside S_COUNT: ignored.
- Saturation: count, above and sum saturate at their all-ones value rather than wrapping.
  - Any saturation sets the sticky frame overflow bit.
  - The overflow bit is copied to the overflow output at frame end and cleared with the accumulators.
- Latency:
  - Pixel accumulated on the edge where it is valid.
  - Results and done visible one cycle after the last-pixel edge.
- busy = (state == S_COUNT), registered from state.
- Output registers hold their values until the next completed frame or reset. Reset mid-frame clears everything immediately (asynchronous).

Test Plan:
- Defaults; start; frame of 4 pixels {10,200,128,129} with threshold=128, in_last on the 4th -> one cycle later done=1 for 1 cycle, total_pixels=4, pixel_sum=467, pixel_min=10, pixel_max=200, above_count=2, overflow=0; state S_DONE until start drops.
- AUTO_RESTART=1; frame A {5,6} (last on 6), immediately followed next cycle by frame B {250} (last) -> two done pulses; after B: total_pixels=1, pixel_sum=250, pixel_min=250, pixel_max=250.
- After a good frame, start a new frame of 3 pixels and assert abort together with the 3rd pixel (in_last=1) -> no done, busy drops, outputs still hold the previous frame's values.
- COUNT_WIDTH=4; frame of 20 pixels of value 1, threshold 0 -> total_pixels=15, above_count=15, overflow=1; pixel_sum=20.
- Gaps: pixel_valid toggling with idle cycles, pixel_valid asserted in S_IDLE and S_DONE -> only in-frame valid pixels are counted; start held high through S_DONE causes no new frame.
- Assert rst_n low mid-frame for 1 cycle -> all outputs at reset values asynchronously (pixel_min all ones); state S_IDLE; a subsequent start/frame works normally.
